// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128/192/256 key schedule engine.
//   Expands a loaded cipher key into all Nr+1 round keys, one 32-bit word per
//   cycle, and serves them through a registered 128-bit read port.
// Ports:
//   clk, reset (async, active low)
//   key_valid/key_ready/key_len/key_in : key load handshake (key MSB-aligned)
//   busy, sched_valid, key_err          : engine status (key_err = 1-cycle pulse)
//   rd_en/rd_idx -> rd_data/rd_valid/rd_err : round-key read, 1-cycle latency
// Optional: define AES_KEY_REVERSE_RD_EN to add rd_dec (read round Nr-rd_idx).
module aes_key_expander #(
  parameter int KEY_MAX      = 256,
  parameter int ZERO_ON_LOAD = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         sched_valid,
  output logic         key_err,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
`ifdef AES_KEY_REVERSE_RD_EN
  input  logic         rd_dec,
`endif
  output logic [127:0] rd_data,
  output logic         rd_valid,
  output logic         rd_err
);

  localparam int WORDS = 4 * (KEY_MAX / 32 + 7);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [31:0]  store_q [WORDS];
  logic [31:0]  win_q   [8];
  logic [31:0]  kw      [8];
  logic [5:0]   i_q, wlast_q;
  logic [2:0]   cnt_q;
  logic [3:0]   nk_q, nr_q, nk_d;
  logic [7:0]   rcon_q;
  logic         sched_valid_q, key_err_q, rd_valid_q, rd_err_q;
  logic [127:0] rd_data_q;

  for (genvar g = 0; g < 8; g++) begin : g_kw
    assign kw[g] = key_in[255-32*g -: 32];
  end

  // Load decode: reject the reserved code and any length above KEY_MAX.
  logic load_req, len_bad, load_acc;
  always_comb begin
    nk_d = 4'd4;
    case (key_len)
      2'b01:   nk_d = 4'd6;
      2'b10:   nk_d = 4'd8;
      default: nk_d = 4'd4;
    endcase
  end
  assign len_bad  = (key_len == 2'b11) || ((128 + 64 * int'(key_len)) > KEY_MAX);
  assign load_req = key_valid && key_ready;
  assign load_acc = load_req && !len_bad;

  // Next schedule word from the sliding window: win[0] = w[i-Nk], win[Nk-1] = w[i-1].
  logic [31:0] prev_w, t_w, new_w;
  always_comb begin
    prev_w = win_q[3'(nk_q - 4'd1)];
    t_w    = prev_w;
    if (cnt_q == 3'd0)
      t_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && cnt_q == 3'd4)
      t_w = sub_word(prev_w);
    new_w = win_q[0] ^ t_w;
  end

  always_comb begin
    state_d = state_q;
    if (load_acc)
      state_d = S_EXPAND;
    else if (state_q == S_EXPAND && i_q == wlast_q)
      state_d = S_DONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      i_q           <= '0;
      wlast_q       <= '0;
      cnt_q         <= '0;
      nk_q          <= 4'd4;
      nr_q          <= 4'd10;
      rcon_q        <= 8'h01;
      sched_valid_q <= 1'b0;
      key_err_q     <= 1'b0;
      for (int j = 0; j < 8; j++) win_q[j] <= '0;
      for (int j = 0; j < WORDS; j++) store_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      key_err_q <= load_req && len_bad;
      if (load_acc) begin
        i_q           <= 6'(nk_d);
        wlast_q       <= 6'(4 * (nk_d + 4'd6) + 3);
        cnt_q         <= '0;
        nk_q          <= nk_d;
        nr_q          <= nk_d + 4'd6;
        rcon_q        <= 8'h01;
        sched_valid_q <= 1'b0;
        for (int j = 0; j < 8; j++) win_q[j] <= kw[j];
      end else if (state_q == S_EXPAND) begin
        i_q   <= i_q + 6'd1;
        cnt_q <= (cnt_q == 3'(nk_q - 4'd1)) ? 3'd0 : cnt_q + 3'd1;
        if (cnt_q == 3'd0)
          rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        for (int j = 0; j < 8; j++) begin
          if (j == int'(nk_q) - 1) win_q[j] <= new_w;
          else if (j < 7)          win_q[j] <= win_q[j+1];
        end
        if (i_q == wlast_q) sched_valid_q <= 1'b1;
      end
      for (int j = 0; j < WORDS; j++) begin
        if (load_acc) begin
          if (j < 8 && j < int'(nk_d)) store_q[j] <= kw[j%8];
          else if (ZERO_ON_LOAD != 0)  store_q[j] <= '0;
        end else if (state_q == S_EXPAND && int'(i_q) == j) begin
          store_q[j] <= new_w;
        end
      end
    end
  end

  // Read port samples the store before any same-cycle load update.
  logic [3:0] idx_eff;
  logic [5:0] base;
  logic       rd_ok;
`ifdef AES_KEY_REVERSE_RD_EN
  assign idx_eff = rd_dec ? (nr_q - rd_idx) : rd_idx;
`else
  assign idx_eff = rd_idx;
`endif
  assign base  = {idx_eff, 2'b00};
  assign rd_ok = sched_valid_q && (rd_idx <= nr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en && rd_ok;
      rd_err_q   <= rd_en && !rd_ok;
      if (rd_en) begin
        if (rd_ok)
          rd_data_q <= {store_q[base], store_q[base + 6'd1],
                        store_q[base + 6'd2], store_q[base + 6'd3]};
        else
          rd_data_q <= '0;
      end
    end
  end

  assign key_ready   = (state_q != S_EXPAND);
  assign busy        = (state_q == S_EXPAND);
  assign sched_valid = sched_valid_q;
  assign key_err     = key_err_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative AES key-schedule engine covering AES-128/192/256; key length selectable per key load.
- Expands a cipher key into all Nr+1 round keys, one 32-bit schedule word per cycle, and holds them in an internal schedule store.
- Cipher round pipelines read round keys by index through a registered read port.
- Successor to the single-round, fixed-128-bit round-key generator; sits between the key-load interface and the round datapath.

Parameters:
- KEY_MAX, 256, largest supported key length in bits (128, 192 or 256); sizes the store at 4*(KEY_MAX/32+7) words.
- ZERO_ON_LOAD, 1, when 1 the store is cleared to zero on every accepted load.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- key_valid  input  1  key load request
- key_ready  output  1  engine can accept a key (IDLE or DONE)
- key_len  input  2  00=128, 01=192, 10=256, 11 illegal
- key_in  input  256  cipher key, MSB-aligned: word0 = key_in[255:224]; unused LSBs ignored
- busy  output  1  expansion in progress
- sched_valid  output  1  full schedule available
- key_err  output  1  one-cycle pulse: illegal or unsupported key_len rejected
- rd_en  input  1  round-key read request
- rd_idx  input  4  round index 0..Nr
- rd_data  output  128  round key, word 4*idx in [127:96]
- rd_valid  output  1  rd_data valid, one cycle after rd_en
- rd_err  output  1  read rejected, same timing as rd_valid

Behaviour:
- Definitions: Nk = 4/6/8; Nr = 10/12/14; total words W = 4*(Nr+1) = 44/52/60.
- Reset (async, active low): state IDLE; key_ready=1; busy, sched_valid, key_err, rd_valid, rd_err = 0; rd_data = 0; store and word window cleared; Rcon = 0x01.
- Handshake: load is accepted when key_valid && key_ready.
  - key_len = 11, or key length > KEY_MAX: load rejected; key_err pulses for one cycle; state and schedule unchanged.
- Accepted load:
  - Nk key words written to store words 0..Nk-1 and to the sliding Nk-word window in the same cycle.
  - sched_valid drops; state goes to EXPAND.
- States: IDLE -> EXPAND (load accepted) -> DONE (word W-1 written) -> EXPAND (new load accepted in DONE). No other transitions.
- EXPAND: one word per cycle, i = Nk..W-1, with t = w[i-1]:
  - i mod Nk == 0: t = SubWord(RotWord(t)) ^ {Rcon,24'h0}; then Rcon <= xtime(Rcon).
  - Nk == 8 and i mod Nk == 4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
  - RotWord rotates left by one byte. SubWord is four combinational S-box lookups. xtime(0x80) = 0x1b.
- Latency: sched_valid rises W-Nk cycles after the accept edge (40/46/52). busy is high exactly during EXPAND.
- In EXPAND: key_ready = 0; key_valid is ignored, with no queuing.
- Reads:
  - Accepted only while sched_valid = 1 and rd_idx <= Nr.
  - Otherwise rd_data = 0, rd_valid = 0, rd_err = 1 for one cycle.
  - A read in the same cycle as a load accept returns the old schedule.
  - rd_data holds its last value when rd_en = 0.
- Reset asserted mid-expansion aborts immediately; all outputs return to reset values.

Optional Feature:
- Macro: AES_KEY_REVERSE_RD_EN.
- Defined:
  - Adds input rd_dec (1 bit).
  - When rd_dec = 1, an accepted read returns round key Nr-rd_idx, for decryption order. Range and error rules are unchanged.
- Undefined:
  - No rd_dec port; reads always use forward order.

Test Plan:
- AES-128 (FIPS-197 A.1): load key 2b7e151628aed2a6abf7158809cf4f3c, key_len=00.
  - Required: sched_valid after 40 cycles.
  - rd_idx 1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 (A.2): key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, key_len=01.
  - Required: 46 cycles to sched_valid.
  - rd_idx 12 -> e98ba06f448c773c8ecc720401002202.
- AES-256 (A.3): key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, key_len=10.
  - Required: 52 cycles to sched_valid.
  - rd_idx 14 -> fe4890d1e6188d0b046df344706c631e.
- Error paths:
  - key_len=11 -> key_err pulse; schedule unchanged.
  - key_valid during EXPAND -> ignored.
  - rd_idx 11 with an AES-128 schedule -> rd_err=1, rd_data=0.
  - Read while busy -> rd_err=1.
- Reset mid-expansion:
  - Drop reset 20 cycles into an AES-256 expansion -> outputs at reset values.
  - Reload the AES-128 key -> correct schedule.
- With AES_KEY_REVERSE_RD_EN defined: after the AES-128 load, rd_dec=1, rd_idx 0 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
